// File: rtl/hsv_core_commit_arbiter.sv
// -----------------------------------------------------------------------------
// hsv_core_commit_arbiter
//
// Merges the result streams of NUM_SRC execution units into the single commit
// port. A round-robin search picks one valid source per cycle and loads its
// payload into a one-entry registered output stage. The core flush handshake
// discards the held entry and blocks new grants while flush_req is high.
//
// Ports
//   clk_core   in   1              core clock, all logic on posedge
//   rst_core   in   1              synchronous active-high reset
//   flush_req  in   1              flush request from the core
//   flush_ack  out  1              flush acknowledge (flush_req delayed 1 cycle)
//   in_valid   in   NUM_SRC        per-source result valid
//   in_ready   out  NUM_SRC        per-source ready, one-hot or zero
//   in_data    in   NUM_SRC*WIDTH  payloads, source i at [i*WIDTH +: WIDTH]
//   out_valid  out  1              commit payload valid
//   out_ready  in   1              commit stage ready
//   out_data   out  WIDTH          granted payload
//   out_src    out  SRC_W          index of the source that produced out_data
// -----------------------------------------------------------------------------
module hsv_core_commit_arbiter #(
    parameter int  NUM_SRC = 4,
    parameter int  WIDTH   = 64,
    localparam int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                     clk_core,
    input  logic                     rst_core,
    input  logic                     flush_req,
    output logic                     flush_ack,
    input  logic [NUM_SRC-1:0]       in_valid,
    output logic [NUM_SRC-1:0]       in_ready,
    input  logic [NUM_SRC*WIDTH-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [SRC_W-1:0]         out_src
);

    logic [SRC_W-1:0] rr_ptr_r;
    logic [SRC_W-1:0] grant_idx_s;
    logic [SRC_W-1:0] next_ptr_s;
    logic             grant_found_s;
    logic             can_load_s;
    logic             load_ok_s;
    logic [WIDTH-1:0] grant_data_s;
    int               cand_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [SRC_W-1:0] out_src_r;
    logic             flush_ack_r;

    // Round-robin search: first valid source starting at rr_ptr_r, wrapping.
    // Candidates are range-checked so a non-power-of-2 NUM_SRC (or a
    // corrupted pointer) can never select an absent source.
    always_comb begin
        grant_idx_s   = '0;
        grant_found_s = 1'b0;
        cand_s        = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand_s = int'(rr_ptr_r) + k;
            if (cand_s >= NUM_SRC) begin
                cand_s = cand_s - NUM_SRC;
            end else begin
                cand_s = cand_s;
            end
            if (!grant_found_s && (cand_s < NUM_SRC) && in_valid[cand_s[SRC_W-1:0]]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s[SRC_W-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Payload mux and pointer advance for the winning source.
    always_comb begin
        grant_data_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_idx_s == SRC_W'(i)) begin
                grant_data_s = in_data[i*WIDTH +: WIDTH];
            end else begin
                grant_data_s = grant_data_s;
            end
        end
        if (grant_idx_s == SRC_W'(NUM_SRC - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_idx_s + SRC_W'(1);
        end
    end

    // Handshake: a grant is only offered when the output stage can accept it,
    // no flush is pending and reset is not asserted.
    always_comb begin
        can_load_s = !out_valid_r || out_ready;
        load_ok_s  = grant_found_s && can_load_s && !flush_req && !rst_core;
        in_ready   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (load_ok_s && (grant_idx_s == SRC_W'(i))) begin
                in_ready[i] = 1'b1;
            end else begin
                in_ready[i] = 1'b0;
            end
        end
    end

    // Output stage, pointer and flush acknowledge registers.
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_src_r   <= '0;
            flush_ack_r <= 1'b0;
            rr_ptr_r    <= '0;
        end else begin
            flush_ack_r <= flush_req;
            if (load_ok_s) begin
                // load_ok_s already implies in_valid of the winner
                out_valid_r <= 1'b1;
                out_data_r  <= grant_data_s;
                out_src_r   <= grant_idx_s;
                rr_ptr_r    <= next_ptr_s;
            end else if (flush_req || out_ready) begin
                // flush discards the entry; otherwise it drained this cycle
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;
    assign flush_ack = flush_ack_r;

endmodule

// File: tb/tb_hsv_core_commit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hsv_core_commit_arbiter
//
// Scoreboard bench. The stimulus side drives one cycle at a time, predicts the
// grant from a queue-based reference model and pushes the expected commit
// entry. A separate monitor checks the output stage every cycle against the
// head of the queue and retires entries when they are taken or flushed.
// -----------------------------------------------------------------------------
module tb_hsv_core_commit_arbiter;

    localparam int N = 4;
    localparam int W = 64;

    logic             clk_core = 1'b0;
    logic             rst_core;
    logic             flush_req;
    logic             flush_ack;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic [N*W-1:0]   in_data;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [1:0]       out_src;

    typedef struct {
        logic [1:0]   src;
        logic [W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_rr    = 0;
    logic m_fack  = 1'b0;
    bit   mon_en  = 1'b0;
    bit   fixed_a5 = 1'b0;

    hsv_core_commit_arbiter #(.NUM_SRC(N), .WIDTH(W)) dut (
        .clk_core  (clk_core),
        .rst_core  (rst_core),
        .flush_req (flush_req),
        .flush_ack (flush_ack),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    always #5 clk_core = ~clk_core;

    // Monitor: compare the output stage with the scoreboard head each cycle.
    initial begin
        forever begin
            @(negedge clk_core);
            if (mon_en) begin
                n_tests++;
                if (out_valid !== (exp_q.size() != 0)) begin
                    n_fail++;
                    $display("FAIL out_valid: got %b expected %b", out_valid, exp_q.size() != 0);
                end
                if (exp_q.size() != 0) begin
                    n_tests++;
                    if (out_src !== exp_q[0].src || out_data !== exp_q[0].data) begin
                        n_fail++;
                        $display("FAIL out_payload: got src %0d data %h expected src %0d data %h",
                                 out_src, out_data, exp_q[0].src, exp_q[0].data);
                    end
                    if (out_ready || flush_req || rst_core) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Reference model step, run after the monitor has retired the leaving entry.
    task automatic model_step();
        logic [N-1:0] er;
        int           g;
        int           s;
        er = '0;
        g  = -1;
        if (!rst_core && !flush_req && exp_q.size() == 0) begin
            for (int k = 0; k < N; k++) begin
                s = (m_rr + k) % N;
                if (g < 0 && in_valid[s[1:0]]) g = s;
            end
        end
        if (g >= 0) er[g[1:0]] = 1'b1;
        n_tests++;
        if (in_ready !== er) begin
            n_fail++;
            $display("FAIL in_ready: got %b expected %b", in_ready, er);
        end
        n_tests++;
        if (flush_ack !== m_fack) begin
            n_fail++;
            $display("FAIL flush_ack: got %b expected %b", flush_ack, m_fack);
        end
        if (rst_core) begin
            exp_q.delete();
            m_rr   = 0;
            m_fack = 1'b0;
        end else begin
            m_fack = flush_req;
            if (g >= 0) begin
                exp_q.push_back('{src: g[1:0], data: W'(in_data >> (g * W))});
                m_rr = (g + 1) % N;
            end
        end
    endtask

    // Drive one cycle of inputs just after the edge, then run the model.
    task automatic drive(input logic [N-1:0] v, input logic rdy, input logic fl, input logic rst);
        @(posedge clk_core);
        #1;
        in_valid  = v;
        out_ready = rdy;
        flush_req = fl;
        rst_core  = rst;
        for (int i = 0; i < N; i++) begin
            if (fixed_a5) in_data[i*W +: W] = 64'h0000_0000_0000_00A5;
            else          in_data[i*W +: W] = {$urandom(), $urandom()};
        end
        @(negedge clk_core);
        #1;
        model_step();
    endtask

    initial begin
        rst_core  = 1'b1;
        flush_req = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        in_data   = '0;
        @(posedge clk_core);
        #1;
        mon_en = 1'b1;

        // Reset state, including reset dominating a flush request
        drive(4'b1111, 1'b1, 1'b1, 1'b1);
        drive(4'b0000, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (out_data !== 64'd0 || out_src !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got data %h src %0d expected 0 0", out_data, out_src);
        end

        // Single source with a known payload
        fixed_a5 = 1'b1;
        drive(4'b0100, 1'b1, 1'b0, 1'b0);
        fixed_a5 = 1'b0;
        drive(4'b0000, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 64'hA5 || out_src !== 2'd2) begin
            n_fail++;
            $display("FAIL single_src: got v %b data %h src %0d expected 1 a5 2",
                     out_valid, out_data, out_src);
        end

        // All valid back-to-back from a fresh pointer
        drive(4'b0000, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) drive(4'b1111, 1'b1, 1'b0, 1'b0);

        // Backpressure for three cycles, then release
        for (int i = 0; i < 3; i++) drive(4'b1111, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) drive(4'b1111, 1'b1, 1'b0, 1'b0);

        // Flush of a held entry
        drive(4'b0001, 1'b0, 1'b0, 1'b0);
        drive(4'b1111, 1'b0, 1'b1, 1'b0);
        drive(4'b0000, 1'b1, 1'b0, 1'b0);
        drive(4'b0000, 1'b1, 1'b0, 1'b0);

        // Pointer wrap: grant source 3, then 0 and 3 compete
        drive(4'b1000, 1'b1, 1'b0, 1'b0);
        drive(4'b1001, 1'b1, 1'b0, 1'b0);
        drive(4'b1001, 1'b1, 1'b0, 1'b0);

        // Reset while an entry is held, then traffic restarts from source 0
        drive(4'b0110, 1'b0, 1'b0, 1'b0);
        drive(4'b1111, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) drive(4'b1111, 1'b1, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(N'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 99) == 0);
        end

        // Drain
        for (int i = 0; i < 3; i++) drive(4'b0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk_core);
        #1;
        n_tests++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: got out_valid %b pending %0d expected 0 0", out_valid, exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
